// File: rtl/servo_pkg.sv
// Shared servo constants and helpers, also used by the PID controller's
// output mapping so both ends agree on the angle range.
package servo_pkg;

  localparam int unsigned MAX_DEG    = 120;
  localparam int unsigned CENTER_DEG = 60;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } servo_state_e;

  // 32-bit arithmetic keeps the full product; callers narrow to their counter width.
  function automatic int unsigned deg_to_cycles(input logic [7:0]  deg,
                                                input int unsigned pulse_min,
                                                input int unsigned cyc_per_deg);
    return pulse_min + 32'(deg) * cyc_per_deg;
  endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Free-running PWM frame counter; flags the last cycle of each frame and
// produces a registered frame_start on the first cycle of the next one.
module servo_frame_timer
  import servo_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = 2000000,
  parameter int unsigned CW           = $clog2(FRAME_CYCLES)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          boundary,
  output logic [CW-1:0] cnt_next,
  output logic          frame_start
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          frame_start_q, frame_start_d;

  always_comb begin
    boundary      = (cnt_q == CW'(FRAME_CYCLES - 1));
    cnt_d         = boundary ? '0 : cnt_q + 1'b1;
    frame_start_d = boundary;
    cnt_next      = cnt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign frame_start = frame_start_q;

endmodule

// File: rtl/servo_pwm_driver.sv
// Hobby-servo PWM driver: one-entry pending angle slot, updates applied only
// at frame boundaries with per-frame slew limiting.
module servo_pwm_driver
  import servo_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES  = 2000000,
  parameter int unsigned PULSE_MIN_CYC = 50000,
  parameter int unsigned CYC_PER_DEG   = 1111,
  parameter int unsigned MAX_DEG       = servo_pkg::MAX_DEG,
  parameter int unsigned SLEW_DEG      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] angle_in,
  input  logic       angle_valid,
  output logic       angle_ready,
  output logic       pwm_out,
  output logic       frame_start,
  output logic [7:0] cur_angle,
  output logic       clamped,
  output logic       running
);

  localparam int unsigned CW       = $clog2(FRAME_CYCLES);
  localparam logic [7:0]  MAX_B    = 8'(MAX_DEG);
  localparam logic [7:0]  SLEW_B   = 8'(SLEW_DEG);
  localparam logic [7:0]  CENTER_B = 8'(CENTER_DEG);

  if (PULSE_MIN_CYC + MAX_DEG * CYC_PER_DEG >= FRAME_CYCLES) begin : g_param_check
    $error("servo_pwm_driver: longest pulse does not fit inside one frame");
  end

  servo_state_e  state_q, state_d;
  logic [7:0]    pend_q, pend_d;
  logic          pend_full_q, pend_full_d;
  logic [7:0]    cur_q, cur_d;
  logic [7:0]    target_q, target_d;
  logic [CW-1:0] pulse_len_q, pulse_len_d;
  logic          clamped_q, clamped_d;
  logic          pwm_q, pwm_d;

  logic          boundary;
  logic [CW-1:0] cnt_next;
  logic [7:0]    nt, diff, step;

  servo_frame_timer #(
    .FRAME_CYCLES (FRAME_CYCLES),
    .CW           (CW)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .boundary    (boundary),
    .cnt_next    (cnt_next),
    .frame_start (frame_start)
  );

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    cur_d       = cur_q;
    target_d    = target_q;
    pulse_len_d = pulse_len_q;
    clamped_d   = clamped_q;
    nt          = target_q;
    diff        = '0;
    step        = '0;

    if (angle_valid && !pend_full_q) begin
      pend_d      = (angle_in > MAX_B) ? MAX_B : angle_in;
      pend_full_d = 1'b1;
      if (angle_in > MAX_B) clamped_d = 1'b1;
    end

    // A transfer on the boundary cycle only fills the slot; it is applied next frame.
    if (boundary) begin
      if (state_q == ST_IDLE) begin
        if (pend_full_q) begin
          state_d     = ST_RUN;
          target_d    = pend_q;
          cur_d       = pend_q;
          pend_full_d = 1'b0;
        end
      end else begin
        if (pend_full_q) begin
          nt          = pend_q;
          target_d    = pend_q;
          pend_full_d = 1'b0;
        end
        diff = (nt >= cur_q) ? nt - cur_q : cur_q - nt;
        step = (SLEW_DEG == 0 || diff <= SLEW_B) ? diff : SLEW_B;
        cur_d = (nt >= cur_q) ? cur_q + step : cur_q - step;
      end
      pulse_len_d = CW'(deg_to_cycles(cur_d, PULSE_MIN_CYC, CYC_PER_DEG));
    end

    pwm_d = (state_d == ST_RUN) && (cnt_next < pulse_len_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      cur_q       <= CENTER_B;
      target_q    <= CENTER_B;
      pulse_len_q <= '0;
      clamped_q   <= 1'b0;
      pwm_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      cur_q       <= cur_d;
      target_q    <= target_d;
      pulse_len_q <= pulse_len_d;
      clamped_q   <= clamped_d;
      pwm_q       <= pwm_d;
    end
  end

  assign angle_ready = ~pend_full_q;
  assign pwm_out     = pwm_q;
  assign cur_angle   = cur_q;
  assign clamped     = clamped_q;
  assign running     = (state_q == ST_RUN);

endmodule

// File: doc/servo_pwm_driver.md
Name: servo_pwm_driver

Overview:
- Consumer end of the PID controller's 0..120 degree rotation output; turns each angle command into a standard hobby-servo PWM waveform.
- Accepts angle samples over a valid/ready handshake and holds them in a one-entry pending register.
- Applies new samples only at frame boundaries, with per-frame slew limiting.
- Drives pwm_out at a fixed frame rate; sits between the PID controller and the servo pin.

Parameters:
- FRAME_CYCLES, 2000000, clk cycles per PWM frame (20 ms at 100 MHz).
- PULSE_MIN_CYC, 50000, pulse width at 0 degrees (0.5 ms).
- CYC_PER_DEG, 1111, extra pulse cycles per degree.
- MAX_DEG, 120, upper angle limit; larger inputs are clamped.
- SLEW_DEG, 4, max angle change per frame; 0 disables slew limiting.
- Constraint: PULSE_MIN_CYC + MAX_DEG*CYC_PER_DEG < FRAME_CYCLES. Violation is an elaboration error.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- angle_in  in  8  commanded angle, unsigned degrees
- angle_valid  in  1  angle_in is valid this cycle
- angle_ready  out  1  pending slot empty; transfer occurs when valid & ready
- pwm_out  out  1  servo PWM signal
- frame_start  out  1  one-cycle pulse on the first cycle of each frame
- cur_angle  out  8  angle currently being driven
- clamped  out  1  sticky; set when an accepted sample exceeded MAX_DEG
- running  out  1  high in state RUN

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset:
  - state=IDLE, frame counter=0, pending empty.
  - cur_angle=60, target=60, pulse_len=0.
  - pwm_out=0, frame_start=0, clamped=0, running=0, angle_ready=1.
- Frame counter cnt counts 0..FRAME_CYCLES-1 and wraps to 0. It runs in both states. The boundary cycle is cnt==FRAME_CYCLES-1.
- Handshake:
  - angle_ready = ~pend_full, combinational from a register.
  - On valid & ready: pend <= min(angle_in, MAX_DEG) and pend_full <= 1.
  - If angle_in > MAX_DEG at that transfer, clamped <= 1. clamped clears only on reset.
  - angle_valid with ready low is ignored; the source must hold valid.
- Boundary cycle in IDLE with pend_full:
  - state <= RUN; target <= pend; cur_angle <= pend directly (no slew on the first sample); pend_full <= 0.
- Boundary cycle in RUN:
  - If pend_full: target <= pend and pend_full <= 0. Define nt as pend in that case, otherwise the old target.
  - cur_angle steps toward nt by min(|nt-cur|, SLEW_DEG). If SLEW_DEG==0, cur_angle <= nt.
- Boundary cycle, any state: pulse_len is computed from the next cur_angle value: pulse_len <= PULSE_MIN_CYC + next_cur*CYC_PER_DEG.
  - Width: pulse_len and cnt are clog2(FRAME_CYCLES) bits.
  - Product is unsigned, at least 8+clog2(CYC_PER_DEG+1) bits; no truncation allowed.
- Sample arriving on the boundary cycle with pending empty: captured into pend and applied at the NEXT boundary. No bypass.
- Sample captured while pending is full is not possible (ready low). A newer sample therefore never overwrites an unapplied one.
- pwm_out is registered: pwm_out <= running_next && (cnt_next < pulse_len_next).
  - In RUN, pwm_out is high for exactly pulse_len cycles starting with frame cycle 0.
  - In IDLE, pwm_out is always 0.
- frame_start is registered and high on the cycle where cnt==0, aligned with the rising edge of pwm_out.
- Reset mid-pulse forces pwm_out low in the same cycle (asynchronous). A truncated pulse is acceptable.
- States: IDLE→RUN on the first applied sample. RUN is left only by reset.

Decomposition:
- Shared package servo_pkg:
  - constants MAX_DEG=120 and CENTER_DEG=60, also used by the PID controller's output mapping;
  - a function deg_to_cycles(deg).
- One natural sub-module, servo_frame_timer: frame counter, boundary strobe and frame_start. The parent holds the handshake, FSM, slew and compare logic.

Test Plan (FRAME_CYCLES=200, PULSE_MIN_CYC=10, CYC_PER_DEG=1, SLEW_DEG=4):
1. Reset, no samples for 3 frames -> pwm_out stays 0, running=0, frame_start pulses every 200 cycles, angle_ready=1.
2. Send 30 in IDLE -> at next boundary running=1, cur_angle=30; pwm_out high exactly 40 cycles per frame, starting with frame_start.
3. In RUN at cur=30, send 50 -> cur_angle 34, 38, ... over successive frames; pulse 44, 48, ..., 60 cycles; 50 is reached after 5 frames and then holds.
4. Send 200 -> accepted as 120, clamped=1 and stays 1. Send 10 in the same pending window -> ready low, 10 not taken until after the boundary.
5. Assert valid exactly on the boundary cycle with pending empty -> value applied one frame later, not in the current frame.
6. Assert rst while pwm_out is high mid-pulse -> pwm_out=0 immediately; cur_angle=60, state IDLE, pend cleared, clamped=0.
